// File: rtl/ws281x_pkg.sv
// Shared WS281x timing constants, ns-to-cycle conversion and receiver state encoding.
// Used by the receiver and by the matching transmitter so both agree on the line timing.
package ws281x_pkg;

   localparam int unsigned ClkFreqDef   = 25_000_000;
   localparam int unsigned ThreshNsDef  = 600;
   localparam int unsigned ResetNsDef   = 50_000;
   localparam int unsigned MaxHighNsDef = 2_000;
   localparam int unsigned MinHighNsDef = 100;

   // Transmit-side pulse shapes, kept here so the driver shares one timing source
   localparam int unsigned T0HighNs = 400;
   localparam int unsigned T1HighNs = 800;
   localparam int unsigned BitNs    = 1_250;

   localparam int unsigned WordW   = 24;
   localparam int unsigned BitCntW = $clog2(WordW);

   typedef enum logic [1:0] {
      WAIT_GAP = 2'd0,
      IDLE     = 2'd1,
      HIGH     = 2'd2,
      LOW      = 2'd3
   } ws281x_rx_state_e;

   // Truncating conversion; MHz first keeps the intermediate product within 32 bits
   function automatic int unsigned ns_to_cycles(input int unsigned clk_freq,
                                                input int unsigned ns);
      return clk_freq / 1_000_000 * ns / 1000;
   endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous inputs, asynchronous active-high reset.
module prim_flop_2sync #(
   parameter int unsigned       Width      = 1,
   parameter logic [Width-1:0]  ResetValue = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [Width-1:0]  d_i,
   output logic [Width-1:0]  q_o
);

   logic [Width-1:0] meta_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= ResetValue;
         q_o    <= ResetValue;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/ws281x_rx.sv
// WS281x serial receiver: measures high-pulse widths to decode bits, assembles 24-bit
// words into a ready/valid holding register and flags latch gaps and protocol errors.
module ws281x_rx
   import ws281x_pkg::*;
#(
   parameter int unsigned ClkFreq   = ClkFreqDef,
   parameter int unsigned ThreshNs  = ThreshNsDef,
   parameter int unsigned ResetNs   = ResetNsDef,
   parameter int unsigned MaxHighNs = MaxHighNsDef,
   parameter int unsigned MinHighNs = MinHighNsDef
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ws281x_din_i,
   output logic [WordW-1:0] data_o,
   output logic             data_valid_o,
   input  logic             data_ready_i,
   output logic             frame_end_o,
   output logic             overflow_o,
   output logic             err_o,
   output logic             idle_o
);

   localparam int unsigned ThreshCycles  = ns_to_cycles(ClkFreq, ThreshNs);
   localparam int unsigned ResetCycles   = ns_to_cycles(ClkFreq, ResetNs);
   localparam int unsigned MaxHighCycles = ns_to_cycles(ClkFreq, MaxHighNs);
   localparam int unsigned MinHighCycles = ns_to_cycles(ClkFreq, MinHighNs);
   localparam int unsigned CntW          = $clog2(ResetCycles + 1);

   ws281x_rx_state_e   state_q, state_d;
   logic               din_s, din_d_q;
   logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc_c;
   logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
   logic [WordW-2:0]   shift_q, shift_d;
   logic [WordW-1:0]   word_c, data_q;
   logic               valid_q, frame_end_q, overflow_q, err_q, idle_q;
   logic               rise_c, gap_hit_c, long_high_c, short_high_c, bit_val_c, last_bit_c;
   logic               word_done_c, err_c, frame_end_c;

   prim_flop_2sync #(
      .Width      (1),
      .ResetValue (1'b0)
   ) u_din_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (ws281x_din_i),
      .q_o   (din_s)
   );

   // One counter serves both high and low run lengths; it never wraps
   assign cnt_inc_c    = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
   assign rise_c       = din_s & ~din_d_q;
   assign gap_hit_c    = cnt_inc_c >= CntW'(ResetCycles);
   assign long_high_c  = cnt_inc_c > CntW'(MaxHighCycles);
   assign short_high_c = cnt_q < CntW'(MinHighCycles);
   assign bit_val_c    = cnt_q >= CntW'(ThreshCycles);
   assign last_bit_c   = bit_cnt_q == BitCntW'(WordW - 1);
   assign word_c       = {shift_q, bit_val_c};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= WAIT_GAP;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_GAP: if (!din_s && gap_hit_c) state_d = IDLE;
         IDLE:     if (rise_c) state_d = HIGH;
         HIGH: begin
            if (!din_s)          state_d = LOW;
            else if (long_high_c) state_d = WAIT_GAP;
         end
         LOW: begin
            if (din_s)                                state_d = HIGH;
            else if (cnt_inc_c == CntW'(ResetCycles)) state_d = IDLE;
         end
         default: state_d = WAIT_GAP;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      word_done_c = 1'b0;
      err_c       = 1'b0;
      frame_end_c = 1'b0;
      case (state_q)
         WAIT_GAP: begin
            // Decoding stays off until a full low gap has been seen
            cnt_d     = (din_s || gap_hit_c) ? '0 : cnt_inc_c;
            bit_cnt_d = '0;
            shift_d   = '0;
         end
         IDLE: cnt_d = rise_c ? CntW'(1) : '0;
         HIGH: begin
            if (din_s) begin
               if (long_high_c) begin
                  err_c     = 1'b1;
                  cnt_d     = '0;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end else begin
               // The falling-edge sample is the first low cycle
               cnt_d = CntW'(1);
               if (short_high_c) begin
                  err_c = 1'b1;
               end else begin
                  shift_d = word_c[WordW-2:0];
                  if (last_bit_c) begin
                     word_done_c = 1'b1;
                     bit_cnt_d   = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BitCntW'(1);
                  end
               end
            end
         end
         LOW: begin
            if (din_s) begin
               cnt_d = CntW'(1);
            end else if (cnt_inc_c == CntW'(ResetCycles)) begin
               frame_end_c = 1'b1;
               cnt_d       = '0;
               bit_cnt_d   = '0;
               shift_d     = '0;
               err_c       = bit_cnt_q != '0;
            end else begin
               cnt_d = cnt_inc_c;
            end
         end
         default: begin
            cnt_d     = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         din_d_q   <= 1'b0;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         din_d_q   <= din_s;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   // Holding register: an unaccepted word is never overwritten
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q      <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         frame_end_q <= 1'b0;
         err_q       <= 1'b0;
         idle_q      <= 1'b1;
      end else begin
         overflow_q  <= word_done_c && valid_q && !data_ready_i;
         frame_end_q <= frame_end_c;
         err_q       <= err_c;
         idle_q      <= (state_d == WAIT_GAP) || (state_d == IDLE);
         if (word_done_c) begin
            if (!valid_q || data_ready_i) begin
               data_q  <= word_c;
               valid_q <= 1'b1;
            end
         end else if (valid_q && data_ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign frame_end_o  = frame_end_q;
   assign overflow_o   = overflow_q;
   assign err_o        = err_q;
   assign idle_o       = idle_q;

endmodule
